// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers used by the key
// schedule and the S-box wrapper.
package aes_pkg;

  localparam int NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? p : 8'h00);
      p   = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h01;
    p   = x;
    for (int i = 1; i < 8; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc ^ {acc[6:0], acc[7]} ^ {acc[5:0], acc[7:6]}
               ^ {acc[4:0], acc[7:5]} ^ {acc[3:0], acc[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sub_bytes.sv
// Single-byte AES S-box (SubBytes), purely combinational.
module aes_sub_bytes
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = sbox(byte_i);

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-boxes, byte i in maps to byte i out.
module aes_sub_word (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sub_bytes u_sbox (
      .byte_i (word_i[8*g +: 8]),
      .byte_o (word_o[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes128_key_sched.sv
// Iterative AES-128 key schedule: one round key per handshake, rounds 0..10,
// next key computed in a single cycle from the registered current key.
module aes128_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rk_idx_q, rk_idx_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [31:0]  w0_s, w1_s, w2_s, w3_s;
  logic [31:0]  sub_s, temp_s;
  logic [31:0]  n0_s, n1_s, n2_s, n3_s;

  assign w0_s = rk_q[127:96];
  assign w1_s = rk_q[95:64];
  assign w2_s = rk_q[63:32];
  assign w3_s = rk_q[31:0];

  aes_sub_word u_sub_word (
    .word_i ({w3_s[23:0], w3_s[31:24]}),
    .word_o (sub_s)
  );

  assign temp_s = sub_s ^ {rcon_q, 24'h000000};
  assign n0_s   = w0_s ^ temp_s;
  assign n1_s   = w1_s ^ n0_s;
  assign n2_s   = w2_s ^ n1_s;
  assign n3_s   = w3_s ^ n2_s;

  always_comb begin
    state_d  = state_q;
    rk_d     = rk_q;
    rk_idx_d = rk_idx_q;
    rcon_d   = rcon_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d  = EMIT;
          rk_d     = key_in;
          rk_idx_d = 4'd0;
          rcon_d   = RCON_INIT;
        end else begin
          state_d  = IDLE;
        end
      end
      EMIT: begin
        // The final handshake leaves rk/rk_idx holding round 10.
        if (rk_ready) begin
          if (rk_idx_q == LAST_IDX) begin
            state_d  = IDLE;
          end else begin
            rk_d     = {n0_s, n1_s, n2_s, n3_s};
            rk_idx_d = rk_idx_q + 4'd1;
            rcon_d   = xtime(rcon_q);
          end
        end else begin
          state_d  = EMIT;
        end
      end
      default: begin
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rk_q     <= 128'h0;
      rk_idx_q <= 4'd0;
      rcon_q   <= RCON_INIT;
    end else begin
      state_q  <= state_d;
      rk_q     <= rk_d;
      rk_idx_q <= rk_idx_d;
      rcon_q   <= rcon_d;
    end
  end

  assign rk        = rk_q;
  assign rk_idx    = rk_idx_q;
  assign rk_valid  = (state_q == EMIT);
  assign key_ready = (state_q == IDLE);
  assign rk_last   = (state_q == EMIT) && (rk_idx_q == LAST_IDX);

endmodule
